cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Downstream of the ALU in the EX stage. Consumes the ALU condition codes (N,Z,C,V), holds the architectural
//  NZCV status register, evaluates the 4-bit instruction condition field against it, and registers the
//  pass/annul decision into the EX/MEM boundary. Later stages use cond_pass_q to commit or annul the instruction.
// PARAMETERS
//  CNT_W     16   width of annul counter (used only when COND_ANNUL_CNT_EN is defined)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  ex_valid     in   1      EX stage holds a real instruction
//  ex_s         in   1      instruction's S bit: update flags
//  ex_cond      in   4      condition field (ARM encoding)
//  alu_n        in   1      ALU negative flag
//  alu_z        in   1      ALU zero flag
//  alu_c        in   1      ALU carry flag
//  alu_v        in   1      ALU overflow flag
//  stall        in   1      hold every register this cycle
//  flush        in   1      kill the EX instruction this cycle
//  cond_now     out  1      combinational: ex_cond evaluated on flags_q (for branch logic in EX)
//  flags_q      out  4      status register {N,Z,C,V}
//  valid_q      out  1      registered: EX/MEM slot holds an instruction
//  cond_pass_q  out  1      registered: that instruction passed its condition
//  annul_cnt    out  CNT_W  count of annulled instructions
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): flags_q=4'b0000, valid_q=0, cond_pass_q=0, annul_cnt=0.
//  cond_now uses flags_q only (never alu_*), so it is the result of the previous flag-setting instruction:
//   0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//   8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V) | D LE Z|(N!=V)
//   E AL 1 | F reserved -> 0 (treated as never)
//  Define adv = !stall & !flush.
//  Priority per edge: reset > flush > stall > normal.
//  flush=1 (stall ignored): valid_q<=0, cond_pass_q<=0, flags_q held, no count.
//  stall=1, flush=0: all registers hold their values; cond_now still reflects flags_q.
//  normal (adv): valid_q<=ex_valid; cond_pass_q<=ex_valid & cond_now.
//  Flag write: flags_q<={alu_n,alu_z,alu_c,alu_v} iff adv & ex_valid & ex_s & cond_now.
//   A failed-condition instruction never writes flags, even with S=1.
//  ex_valid=0 with adv: bubble; valid_q<=0, cond_pass_q<=0, flags held.
//  Latency: cond_pass_q and flags_q are visible 1 cycle after the EX cycle. Back-to-back dependent
//   instructions need no stall: instr i+1 sees instr i's flags in flags_q.
// CONFIGURATION
//  COND_ANNUL_CNT_EN defined: annul_cnt increments by 1 on each adv & ex_valid & !cond_now edge.
//   It saturates at all-ones (no wrap) and is held during stall and flush.
//  COND_ANNUL_CNT_EN undefined: annul_cnt is constant 0 and no counter flops exist.
// TESTING
//  1 reset, then ex_valid=1 ex_cond=E -> next cycle valid_q=1, cond_pass_q=1, flags_q=0000
//  2 ex_s=1 cond=E with alu NZCV=0100 -> flags_q=0100; next instr cond=0 (EQ) -> cond_pass_q=1, cond=1 (NE) -> 0
//  3 flags_q=1001 (N=V): cond=A (GE) passes, cond=B (LT) fails; ex_s=1 on the LT instr with alu=0110 -> flags stay 1001
//  4 stall=1 for 3 cycles with changing alu_* and ex_s=1 -> flags_q/valid_q/cond_pass_q unchanged; flush=1 & stall=1 -> valid_q=0
//  5 reset asserted asynchronously mid-cycle with flags_q=1111, valid_q=1 -> all outputs 0 before the next edge
//  6 [COND_ANNUL_CNT_EN] 5 failed cond=F instrs -> annul_cnt=5; CNT_W=4 with 20 fails -> holds 4'hF; undefined -> annul_cnt stays 0

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Sits in the EX stage behind the ALU. It holds the architectural NZCV
//   status register and evaluates the instruction condition field against it.
//   It also registers the pass/annul decision into the EX/MEM boundary.
//
//   Optional feature macro: COND_ANNUL_CNT_EN
//     When it is defined, a saturating counter of annulled instructions is
//     built. When it is undefined, annul_cnt is tied to zero and no counter
//     flops exist.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   ex_valid     in   EX stage holds a real instruction
//   ex_s         in   instruction S bit (update flags)
//   ex_cond      in   [3:0] ARM condition field
//   alu_n/z/c/v  in   ALU condition codes
//   stall        in   hold every register this cycle
//   flush        in   kill the EX instruction this cycle
//   cond_now     out  ex_cond evaluated on flags_q (combinational)
//   flags_q      out  [3:0] status register {N,Z,C,V}
//   valid_q      out  EX/MEM slot holds an instruction
//   cond_pass_q  out  that instruction passed its condition
//   annul_cnt    out  [CNT_W-1:0] count of annulled instructions
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_s,
  input  logic [3:0]       ex_cond,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             stall,
  input  logic             flush,
  output logic             cond_now,
  output logic [3:0]       flags_q,
  output logic             valid_q,
  output logic             cond_pass_q,
  output logic [CNT_W-1:0] annul_cnt
);

  logic       adv;
  logic [3:0] flags_d;
  logic       valid_d;
  logic       pass_d;
  logic       fn, fz, fc, fv;

  assign adv = !stall && !flush;
  assign {fn, fz, fc, fv} = flags_q;

  // cond_now looks only at the committed flags, never at alu_*. A dependent
  // instruction therefore sees the previous flag setter without a bypass path.
  always_comb begin
    cond_now = 1'b0;
    unique case (ex_cond)
      4'h0: cond_now = fz;
      4'h1: cond_now = !fz;
      4'h2: cond_now = fc;
      4'h3: cond_now = !fc;
      4'h4: cond_now = fn;
      4'h5: cond_now = !fn;
      4'h6: cond_now = fv;
      4'h7: cond_now = !fv;
      4'h8: cond_now = fc && !fz;
      4'h9: cond_now = !fc || fz;
      4'hA: cond_now = (fn == fv);
      4'hB: cond_now = (fn != fv);
      4'hC: cond_now = !fz && (fn == fv);
      4'hD: cond_now = fz || (fn != fv);
      4'hE: cond_now = 1'b1;
      4'hF: cond_now = 1'b0;  // reserved encoding, treated as never
      default: cond_now = 1'b0;
    endcase
  end

  // Flush takes priority over stall. A flush kills the slot but leaves the
  // flags alone.
  always_comb begin
    flags_d = flags_q;
    valid_d = valid_q;
    pass_d  = cond_pass_q;
    if (flush) begin
      valid_d = 1'b0;
      pass_d  = 1'b0;
    end else if (!stall) begin
      valid_d = ex_valid;
      pass_d  = ex_valid && cond_now;
      // A failed-condition instruction never writes flags, even with S set.
      if (ex_valid && ex_s && cond_now)
        flags_d = {alu_n, alu_z, alu_c, alu_v};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      cond_pass_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      cond_pass_q <= pass_d;
    end
  end

`ifdef COND_ANNUL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (adv && ex_valid && !cond_now && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign annul_cnt = cnt_q;
`else
  assign annul_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;
  localparam int CW = 4;
`ifdef COND_ANNUL_CNT_EN
  localparam bit ANNUL_ON = 1'b1;
`else
  localparam bit ANNUL_ON = 1'b0;
`endif

  logic clk = 0, reset = 1;
  logic ex_valid = 0, ex_s = 0, stall = 0, flush = 0;
  logic [3:0] ex_cond = 4'hE;
  logic alu_n = 0, alu_z = 0, alu_c = 0, alu_v = 0;
  logic cond_now, valid_q, cond_pass_q;
  logic [3:0] flags_q;
  logic [CW-1:0] annul_cnt;

  int n_cmp = 0, n_fail = 0;

  // reference model state
  logic [3:0] m_flags;
  logic m_valid, m_pass;
  int m_cnt;

  cond_flag_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_s(ex_s), .ex_cond(ex_cond),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .stall(stall), .flush(flush), .cond_now(cond_now), .flags_q(flags_q),
    .valid_q(valid_q), .cond_pass_q(cond_pass_q), .annul_cnt(annul_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit s; bit [3:0] cond; bit [3:0] alu; bit st; bit fl;
    bit e_valid; bit e_pass; bit [3:0] e_flags;
  } vec_t;

  // Condition truth written from the mnemonic meanings.
  function automatic bit model_cond(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (int'(c))
      0: return z;
      1: return !z;
      2: return cy;
      3: return !cy;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cy && !z;
      9: return !(cy && !z);
      10: return n == v;
      11: return !(n == v);
      12: return !z && n == v;
      13: return !(!z && n == v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flags = 0; m_valid = 0; m_pass = 0; m_cnt = 0;
  endtask

  // Drive one EX cycle, check cond_now before the edge, and advance the
  // model across the edge.
  task automatic apply(input bit v, input bit s, input logic [3:0] c,
                       input logic [3:0] alu, input bit st, input bit fl);
    bit p;
    ex_valid = v; ex_s = s; ex_cond = c; {alu_n, alu_z, alu_c, alu_v} = alu;
    stall = st; flush = fl;
    #1;
    p = model_cond(m_flags, c);
    chk("cond_now", cond_now, p);
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_pass = 0;
    end else if (!st) begin
      m_valid = v; m_pass = v && p;
      if (v && s && p) m_flags = alu;
      if (v && !p && ANNUL_ON && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
  endtask

  task automatic chk_model();
    chk("flags_q", flags_q, m_flags);
    chk("valid_q", valid_q, m_valid);
    chk("cond_pass_q", cond_pass_q, m_pass);
    chk("annul_cnt", annul_cnt, m_cnt);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  vec_t vt[$];

  initial begin
    model_reset();
    // directed vectors, starting right after reset (flags 0000)
    //          v  s  cond  alu    st fl  ev ep eflags
    vt.push_back('{1, 0, 4'hE, 4'h0, 0, 0, 1, 1, 4'b0000});
    vt.push_back('{1, 1, 4'hE, 4'h4, 0, 0, 1, 1, 4'b0100});
    vt.push_back('{1, 0, 4'h0, 4'h0, 0, 0, 1, 1, 4'b0100});
    vt.push_back('{1, 0, 4'h1, 4'h0, 0, 0, 1, 0, 4'b0100});
    vt.push_back('{1, 1, 4'hE, 4'h9, 0, 0, 1, 1, 4'b1001});
    vt.push_back('{1, 0, 4'hA, 4'h0, 0, 0, 1, 1, 4'b1001});
    vt.push_back('{1, 1, 4'hB, 4'h6, 0, 0, 1, 0, 4'b1001});
    vt.push_back('{1, 1, 4'hE, 4'hF, 1, 0, 1, 0, 4'b1001});
    vt.push_back('{1, 1, 4'hE, 4'h3, 1, 0, 1, 0, 4'b1001});
    vt.push_back('{1, 1, 4'hE, 4'h7, 1, 0, 1, 0, 4'b1001});
    vt.push_back('{1, 1, 4'hE, 4'h7, 1, 1, 0, 0, 4'b1001});
    vt.push_back('{0, 1, 4'hE, 4'h0, 0, 0, 0, 0, 4'b1001});
    vt.push_back('{1, 1, 4'hC, 4'hA, 0, 0, 1, 1, 4'b1010});
    vt.push_back('{1, 0, 4'hD, 4'h0, 0, 0, 1, 1, 4'b1010});
    vt.push_back('{1, 0, 4'h8, 4'h0, 0, 0, 1, 1, 4'b1010});
    vt.push_back('{1, 1, 4'hF, 4'h0, 0, 0, 1, 0, 4'b1010});

    do_reset();
    #1;
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_valid", valid_q, 1'b0);
    chk("rst_pass", cond_pass_q, 1'b0);
    chk("rst_cnt", annul_cnt, 0);

    foreach (vt[i]) begin
      apply(vt[i].v, vt[i].s, vt[i].cond, vt[i].alu, vt[i].st, vt[i].fl);
      chk($sformatf("vec%0d_valid", i), valid_q, vt[i].e_valid);
      chk($sformatf("vec%0d_pass", i), cond_pass_q, vt[i].e_pass);
      chk($sformatf("vec%0d_flags", i), flags_q, vt[i].e_flags);
      chk($sformatf("vec%0d_cnt", i), annul_cnt, m_cnt);
    end
    // three annuls counted (NE, LT, F); the stalled and flushed slots are not
    chk("vec_cnt_total", annul_cnt, ANNUL_ON ? 3 : 0);

    // asynchronous reset in the middle of a cycle
    apply(1, 1, 4'hE, 4'hF, 0, 0);
    chk("pre_async_flags", flags_q, 4'hF);
    chk("pre_async_valid", valid_q, 1'b1);
    @(negedge clk); #2;
    reset = 1;
    #1;
    chk("async_flags", flags_q, 4'h0);
    chk("async_valid", valid_q, 1'b0);
    chk("async_pass", cond_pass_q, 1'b0);
    chk("async_cnt", annul_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 0;

    // annul counter: 5 failures, then saturation at all-ones
    for (int i = 0; i < 5; i++) apply(1, 0, 4'hF, 4'h0, 0, 0);
    chk("annul5", annul_cnt, ANNUL_ON ? 5 : 0);
    apply(1, 0, 4'hF, 4'h0, 1, 0);
    apply(1, 0, 4'hF, 4'h0, 0, 1);
    chk("annul_hold", annul_cnt, ANNUL_ON ? 5 : 0);
    for (int i = 0; i < 15; i++) apply(1, 0, 4'hF, 4'h0, 0, 0);
    chk("annul_sat", annul_cnt, ANNUL_ON ? 15 : 0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      chk_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
